// File: rtl/simple_dp_sched_pkg.sv
// Shared types and limits for the round-robin datapath scheduler.
package simple_dp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    FLUSH
  } state_t;

  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/simple_rr_pick.sv
// Round-robin priority finder: first set request at or after ptr, wrapping modulo N_REQ.
module simple_rr_pick #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [TAG_W-1:0] ptr,
  output logic [TAG_W-1:0] winner,
  output logic             found
);

  localparam logic [TAG_W:0] N_L = (TAG_W + 1)'(N_REQ);

  logic [TAG_W:0] idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // Scan from the farthest offset back towards ptr so the closest hit is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (TAG_W + 1)'(k);
      if (idx >= N_L) idx = idx - N_L;
      if (req[idx[TAG_W-1:0]]) begin
        winner = idx[TAG_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_dp_sched.sv
// Round-robin scheduler sharing one external NAND/NOR flop datapath among N_REQ requesters;
// grants one requester, drives its operands for a cycle, and returns the result LAT cycles later.
module simple_dp_sched
  import simple_dp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             tau2015_clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op_a,
  input  logic [N_REQ-1:0] op_b,
  output logic [N_REQ-1:0] gnt,
  output logic             dp_inp1,
  output logic             dp_inp2,
  input  logic             dp_out,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_data,
  output logic             busy
);

  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_t           state;
  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] tag;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] winner;
  logic             found;

  simple_rr_pick #(
    .N_REQ (N_REQ),
    .TAG_W (TAG_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tag       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      dp_inp1   <= 1'b0;
      dp_inp2   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_data  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= ONE_HOT0 << winner;
            dp_inp1 <= op_a[winner];
            dp_inp2 <= op_b[winner];
            tag     <= winner;
            ptr     <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= DRIVE;
          end
        end

        // Inputs return to zero after the drive cycle, which lets the datapath flop clear itself.
        DRIVE, WAIT: begin
          gnt     <= '0;
          dp_inp1 <= 1'b0;
          dp_inp2 <= 1'b0;
          if (cnt == '0) begin
            rsp_data  <= dp_out;
            rsp_valid <= 1'b1;
            rsp_tag   <= tag;
            state     <= FLUSH;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= WAIT;
          end
        end

        FLUSH: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_dp_sched.sv
// Bench for simple_dp_sched: three instances (LAT 2, 4, 1) each with a datapath model,
// a per-cycle reference model of the scheduling rules, and directed literal checks.
module tb_simple_dp_sched;

  localparam int N  = 4;
  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 4 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_v   [NI];
  logic [N-1:0] req_v   [NI];
  logic [N-1:0] op_a_v  [NI];
  logic [N-1:0] op_b_v  [NI];
  logic [N-1:0] gnt_v   [NI];
  logic         inp1_v  [NI];
  logic         inp2_v  [NI];
  logic         valid_v [NI];
  logic [1:0]   tag_v   [NI];
  logic         data_v  [NI];
  logic         busy_v  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L  = lat_of(g);
    localparam int HI = (L >= 2) ? L - 2 : 0;

    logic dpo;
    logic dq = 1'b0;
    logic hist [16] = '{default: 1'b0};
    logic d;

    simple_dp_sched #(
      .N_REQ (N),
      .LAT   (L)
    ) u_dut (
      .tau2015_clk (clk),
      .rst         (rst_v[g]),
      .req         (req_v[g]),
      .op_a        (op_a_v[g]),
      .op_b        (op_b_v[g]),
      .gnt         (gnt_v[g]),
      .dp_inp1     (inp1_v[g]),
      .dp_inp2     (inp2_v[g]),
      .dp_out      (dpo),
      .rsp_valid   (valid_v[g]),
      .rsp_tag     (tag_v[g]),
      .rsp_data    (data_v[g]),
      .busy        (busy_v[g])
    );

    // External datapath: q' = (a&b)&~q, result presented LAT-1 registers later.
    assign d = inp1_v[g] & inp2_v[g] & ~dq;
    always @(posedge clk) begin
      dq      <= d;
      hist[0] <= d;
      for (int k = 1; k < 16; k++) hist[k] <= hist[k-1];
    end
    assign dpo = (L == 1) ? d : hist[HI];

    // Reference model: operation timeline by absolute edge number.
    int           m_e     = 0;
    int           m_next  = 0;
    int           m_op    = -1000;
    int           m_ptr   = 0;
    int           m_tag   = 0;
    bit           m_a     = 1'b0;
    bit           m_b     = 1'b0;
    bit           m_armed = 1'b0;
    logic [N-1:0] x_gnt   = '0;
    logic         x_i1    = 1'b0;
    logic         x_i2    = 1'b0;
    logic         x_v     = 1'b0;
    logic         x_busy  = 1'b0;
    logic [1:0]   x_tag   = '0;
    logic         x_data  = 1'b0;

    always @(posedge clk) begin : model
      int           e, w, c, op, tg;
      bit           a, b;
      logic [N-1:0] rv;
      e  = m_e + 1;
      op = m_op;
      tg = m_tag;
      a  = m_a;
      b  = m_b;
      rv = req_v[g];
      m_e <= e;
      if (rst_v[g]) begin
        m_armed <= 1'b1;
        m_ptr   <= 0;
        m_next  <= e + 1;
        m_op    <= -1000;
        x_gnt   <= '0;
        x_i1    <= 1'b0;
        x_i2    <= 1'b0;
        x_v     <= 1'b0;
        x_busy  <= 1'b0;
        x_tag   <= '0;
        x_data  <= 1'b0;
      end else begin
        if (e >= m_next && rv != '0) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (w < 0 && rv[c]) w = c;
          end
          op = e;
          tg = w;
          a  = op_a_v[g][w];
          b  = op_b_v[g][w];
          m_op   <= op;
          m_tag  <= tg;
          m_a    <= a;
          m_b    <= b;
          m_ptr  <= (w + 1) % N;
          m_next <= e + L + 2;
        end
        x_gnt  <= (op == e) ? (4'b0001 << tg) : 4'b0000;
        x_i1   <= (op == e) && a;
        x_i2   <= (op == e) && b;
        x_busy <= (e >= op) && (e <= op + L);
        x_v    <= (e == op + L);
        if (e == op + L) begin
          x_tag  <= 2'(tg);
          x_data <= a & b;
        end
      end
    end

    always @(negedge clk) begin
      if (m_armed) begin
        check($sformatf("i%0d gnt", g),       int'(gnt_v[g]),   int'(x_gnt));
        check($sformatf("i%0d dp_inp1", g),   int'(inp1_v[g]),  int'(x_i1));
        check($sformatf("i%0d dp_inp2", g),   int'(inp2_v[g]),  int'(x_i2));
        check($sformatf("i%0d rsp_valid", g), int'(valid_v[g]), int'(x_v));
        check($sformatf("i%0d busy", g),      int'(busy_v[g]),  int'(x_busy));
        check($sformatf("i%0d rsp_tag", g),   int'(tag_v[g]),   int'(x_tag));
        check($sformatf("i%0d rsp_data", g),  int'(data_v[g]),  int'(x_data));
      end
    end
  end

  // Drive one requester pattern until ng grants are issued and ng responses return.
  task automatic serve(input int i, input logic [N-1:0] r, input int ng,
                       input logic [N-1:0] a_seq [8], input logic [N-1:0] b_seq [8],
                       output int g_idx [8], output int g_cyc [8],
                       output int r_tag [8], output int r_dat [8], output int r_cyc [8]);
    int ng_seen = 0;
    int nr_seen = 0;
    int cyc     = 0;
    for (int k = 0; k < 8; k++) begin
      g_idx[k] = -1; g_cyc[k] = -1; r_tag[k] = -1; r_dat[k] = -1; r_cyc[k] = -1;
    end
    repeat (2) @(negedge clk);
    req_v[i]  = r;
    op_a_v[i] = a_seq[0];
    op_b_v[i] = b_seq[0];
    while (nr_seen < ng && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gnt_v[i] != '0 && ng_seen < 8) begin
        for (int k = 0; k < N; k++) if (gnt_v[i][k]) g_idx[ng_seen] = k;
        g_cyc[ng_seen] = cyc;
        ng_seen++;
        if (ng_seen >= ng) req_v[i] = '0;
        else begin
          op_a_v[i] = a_seq[ng_seen];
          op_b_v[i] = b_seq[ng_seen];
        end
      end
      if (valid_v[i] && nr_seen < 8) begin
        r_tag[nr_seen] = int'(tag_v[i]);
        r_dat[nr_seen] = int'(data_v[i]);
        r_cyc[nr_seen] = cyc;
        nr_seen++;
      end
    end
    req_v[i] = '0;
    check($sformatf("i%0d response count", i), nr_seen, ng);
  endtask

  initial begin : stim
    logic [N-1:0] sa [8];
    logic [N-1:0] sb [8];
    int gi [8], gc [8], rt [8], rd [8], rc [8];
    int fair_idx [8];
    int fair_dat [8];
    int tt_dat [4];
    int nv, cyc;

    fair_idx = '{0, 1, 2, 3, 0, 1, 2, 3};
    fair_dat = '{1, 0, 1, 0, 1, 0, 1, 0};
    tt_dat   = '{0, 0, 0, 1};

    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1; req_v[i] = '0; op_a_v[i] = '0; op_b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset i%0d gnt", i),       int'(gnt_v[i]),   0);
      check($sformatf("reset i%0d busy", i),      int'(busy_v[i]),  0);
      check($sformatf("reset i%0d rsp_valid", i), int'(valid_v[i]), 0);
      check($sformatf("reset i%0d rsp_tag", i),   int'(tag_v[i]),   0);
      rst_v[i] = 1'b0;
    end

    // Fairness on LAT=2: all four held, order 0,1,2,3,0,... every LAT+2 cycles.
    for (int k = 0; k < 8; k++) begin sa[k] = 4'b0101; sb[k] = 4'b0111; end
    serve(0, 4'b1111, 8, sa, sb, gi, gc, rt, rd, rc);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fair idx %0d", k),  gi[k], fair_idx[k]);
      check($sformatf("fair data %0d", k), rd[k], fair_dat[k]);
      check($sformatf("fair tag %0d", k),  rt[k], fair_idx[k]);
    end
    for (int k = 0; k < 7; k++) check($sformatf("fair gap %0d", k), gc[k+1] - gc[k], 4);

    // Single op on LAT=2.
    for (int k = 0; k < 8; k++) begin sa[k] = 4'b0001; sb[k] = 4'b0001; end
    serve(0, 4'b0001, 1, sa, sb, gi, gc, rt, rd, rc);
    check("single gnt idx", gi[0], 0);
    check("single gnt cycle", gc[0], 1);
    check("single rsp cycle", rc[0], 3);
    check("single rsp tag", rt[0], 0);
    check("single rsp data", rd[0], 1);

    // Truth table through requester 2; other bits carry the opposite value.
    for (int k = 0; k < 4; k++) begin
      sa[k] = (k >= 2)      ? 4'b0100 : 4'b1011;
      sb[k] = (k % 2 == 1)  ? 4'b0100 : 4'b1011;
    end
    serve(0, 4'b0100, 4, sa, sb, gi, gc, rt, rd, rc);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("truth data %0d", k), rd[k], tt_dat[k]);
      check($sformatf("truth tag %0d", k),  rt[k], 2);
    end
    for (int k = 0; k < 3; k++) check($sformatf("truth gap %0d", k), gc[k+1] - gc[k], 4);

    // Pointer now at 3: sparse 0101 must wrap to 0, then 2, then 0.
    for (int k = 0; k < 8; k++) begin sa[k] = 4'b1111; sb[k] = 4'b1111; end
    serve(0, 4'b0101, 3, sa, sb, gi, gc, rt, rd, rc);
    check("wrap idx 0", gi[0], 0);
    check("wrap idx 1", gi[1], 2);
    check("wrap idx 2", gi[2], 0);

    // Reset mid-WAIT on LAT=4.
    @(negedge clk);
    req_v[1] = 4'b0010; op_a_v[1] = 4'b1111; op_b_v[1] = 4'b1111;
    cyc = 0;
    while (gnt_v[1] == '0 && cyc < 20) begin @(negedge clk); cyc++; end
    check("midwait gnt", int'(gnt_v[1]), 2);
    req_v[1] = '0;
    repeat (2) @(negedge clk);
    check("midwait busy before rst", int'(busy_v[1]), 1);
    rst_v[1] = 1'b1;
    @(negedge clk);
    check("midwait rst gnt", int'(gnt_v[1]), 0);
    check("midwait rst busy", int'(busy_v[1]), 0);
    check("midwait rst valid", int'(valid_v[1]), 0);
    check("midwait rst inp1", int'(inp1_v[1]), 0);
    rst_v[1] = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (valid_v[1]) nv++; end
    check("midwait dropped rsp", nv, 0);
    serve(1, 4'b1001, 1, sa, sb, gi, gc, rt, rd, rc);
    check("post-rst idx", gi[0], 0);
    check("post-rst tag", rt[0], 0);
    check("post-rst data", rd[0], 1);
    check("post-rst latency", rc[0] - gc[0], 4);

    // LAT=1: DRIVE goes straight to FLUSH; two back-to-back ops from one requester.
    for (int k = 0; k < 8; k++) begin sa[k] = 4'b0010; sb[k] = 4'b0010; end
    serve(2, 4'b0010, 2, sa, sb, gi, gc, rt, rd, rc);
    check("lat1 gnt cycle", gc[0], 1);
    check("lat1 rsp cycle 0", rc[0], 2);
    check("lat1 gap", gc[1] - gc[0], 3);
    check("lat1 data 0", rd[0], 1);
    check("lat1 data 1", rd[1], 1);
    check("lat1 tag 1", rt[1], 1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timed out");
  end

endmodule
